// File: rtl/ssram_responder.sv
// SSRAM-style slave backed by an internal word RAM: pipelined reads with
// waitrequest stall, single-cycle byte-enabled writes and a 4-word wrapping burst counter.
module ssram_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_select,
  input  logic        i_read,
  input  logic        i_write,
  input  logic        i_start,
  input  logic        i_burst,
  input  logic        i_burst_adv,
  input  logic [31:0] i_address,
  input  logic [3:0]  i_be,
  input  logic [31:0] i_writedata,
  output logic [31:0] o_readdata,
  output logic        o_readvalid,
  output logic        o_waitrequest
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // LATENCY is legal in 1..4, so the wait counter never exceeds 3
  localparam logic [2:0]            LP_CNT_INIT  = 3'(LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] LP_WRAP_MASK = ADDR_WIDTH'(3);

  logic [31:0]           r_mem [0:DEPTH-1];
  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [2:0]            r_count;
  logic [2:0]            w_count_nxt;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [31:0]           r_readdata;
  logic                  r_readvalid;

  logic                  w_idle;
  logic                  w_new_addr;
  logic [ADDR_WIDTH-1:0] w_eff;
  logic [ADDR_WIDTH-1:0] w_adv_addr;
  logic [ADDR_WIDTH-1:0] w_fetch_addr;
  logic                  w_accept;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic                  w_load_data;

  assign w_idle     = (r_state == S_IDLE);
  assign w_new_addr = i_start | i_burst;
  assign w_eff      = w_new_addr ? i_address[ADDR_WIDTH+1:2] : r_addr_q;
  // Advance only the low two word bits so bursts wrap inside the aligned 4-word block
  assign w_adv_addr = (w_eff & ~LP_WRAP_MASK) | ((w_eff + ADDR_WIDTH'(1)) & LP_WRAP_MASK);

  assign w_accept = w_idle & i_select & (i_read | i_write);
  assign w_wr_en  = w_idle & i_select & i_write;
  assign w_rd_en  = w_idle & i_select & i_read & ~i_write;

  assign w_fetch_addr  = w_idle ? w_eff : r_rd_addr;
  assign w_load_data   = (w_state_nxt == S_DONE) && (r_state != S_DONE);
  assign o_waitrequest = w_rd_en | (r_state == S_WAIT);
  assign o_readdata    = r_readdata;
  assign o_readvalid   = r_readvalid;

  // Read FSM next-state and wait-counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      S_IDLE: begin
        if (w_rd_en) begin
          if (LATENCY <= 1) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_WAIT;
            w_count_nxt = LP_CNT_INIT;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        w_count_nxt = r_count - 3'd1;
        if (r_count <= 3'd1) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = 3'd0;
      end
    endcase
  end

  // FSM state, counter and captured read address
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_count   <= 3'd0;
      r_rd_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_rd_en) begin
        r_rd_addr <= w_eff;
      end
    end
  end

  // Burst address register; address-only cycles also load it
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr_q <= '0;
    end else if (w_idle) begin
      if (w_accept) begin
        if (i_burst_adv) begin
          r_addr_q <= w_adv_addr;
        end else if (w_new_addr) begin
          r_addr_q <= w_eff;
        end
      end else if (w_new_addr) begin
        r_addr_q <= w_eff;
      end
    end
  end

  // Byte-enabled RAM write; contents survive reset
  always_ff @(posedge i_clk) begin
    if (w_wr_en && !i_reset) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          r_mem[w_eff][8*b +: 8] <= i_writedata[8*b +: 8];
        end
      end
    end
  end

  // Read data register, loaded on entry to DONE and held otherwise
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_readdata  <= 32'd0;
      r_readvalid <= 1'b0;
    end else if (w_load_data) begin
      r_readdata  <= r_mem[w_fetch_addr];
      r_readvalid <= 1'b1;
    end else begin
      r_readvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ssram_responder.sv
// Self-checking bench for ssram_responder: vector table plus hand-written
// burst, reset-abort and read&write sequences, with a readdata scoreboard.
module tb_ssram_responder;

  localparam int LAT = 2;
  localparam int AW  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        select, read, write, start, burst, burst_adv;
  logic [31:0] address, writedata, readdata;
  logic [3:0]  be;
  logic        readvalid, waitrequest;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        is_read;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  ssram_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .i_clk(clk), .i_reset(reset), .i_select(select), .i_read(read),
    .i_write(write), .i_start(start), .i_burst(burst), .i_burst_adv(burst_adv),
    .i_address(address), .i_be(be), .i_writedata(writedata),
    .o_readdata(readdata), .o_readvalid(readvalid), .o_waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
  endtask

  // Scoreboard: every readvalid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (readvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_readvalid: got 1 expected 0 (data %h) at %0t", readdata, $time);
      end else begin
        check("readdata", readdata, exp_q.pop_front());
      end
    end
  end

  task automatic idle_inputs();
    select = 1'b0; read = 1'b0; write = 1'b0; start = 1'b0; burst = 1'b0;
    burst_adv = 1'b0; address = 32'd0; be = 4'd0; writedata = 32'd0;
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge
  task automatic do_write(input logic [31:0] addr, input logic [3:0] b,
                          input logic [31:0] data, input logic with_read);
    select = 1'b1; write = 1'b1; read = with_read; start = 1'b1;
    address = addr; be = b; writedata = data; burst_adv = 1'b0;
    @(negedge clk);
    check("write_waitrequest", {31'd0, waitrequest}, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic do_read(input logic [31:0] addr, input logic st, input logic adv,
                         input logic [31:0] want);
    int n;
    exp_q.push_back(want);
    select = 1'b1; read = 1'b1; write = 1'b0; start = st; address = addr; burst_adv = adv;
    n = 0;
    @(negedge clk);
    while (waitrequest === 1'b1 && n < 20) begin
      check("readvalid_low_while_stalled", {31'd0, readvalid}, 32'd0);
      n++;
      @(negedge clk);
    end
    check("read_stall_cycles", 32'(n), 32'(LAT));
    @(posedge clk); #1;
    idle_inputs();
    check("readvalid_one_cycle", {31'd0, readvalid}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h10,   4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 32'h10,   4'h0, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b0, 32'h20,   4'hF, 32'h11223344, 32'h0};
    vecs[3] = '{1'b0, 32'h20,   4'h5, 32'hAABBCCDD, 32'h0};
    vecs[4] = '{1'b1, 32'h20,   4'h0, 32'h0,        32'h11BB33DD};
    vecs[5] = '{1'b0, 32'h20,   4'h0, 32'hFFFFFFFF, 32'h0};
    vecs[6] = '{1'b1, 32'h20,   4'h0, 32'h0,        32'h11BB33DD};
    vecs[7] = '{1'b0, 32'h1004, 4'hF, 32'hCAFEF00D, 32'h0};
    vecs[8] = '{1'b1, 32'h0004, 4'h0, 32'h0,        32'hCAFEF00D};

    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_readdata",    readdata, 32'd0);
    check("reset_readvalid",   {31'd0, readvalid}, 32'd0);
    check("reset_waitrequest", {31'd0, waitrequest}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].is_read) do_read(vecs[i].addr, 1'b1, 1'b0, vecs[i].exp);
      else do_write(vecs[i].addr, vecs[i].be, vecs[i].wdata, 1'b0);
    end

    // Burst: start at 0x48, advance each beat, wrap 0x4C -> 0x40
    for (int i = 0; i < 4; i++) begin
      do_write(32'h40 + 32'(4 * i), 4'hF, 32'hB0000000 + 32'(i), 1'b0);
    end
    do_read(32'h48, 1'b1, 1'b1, 32'hB0000002);
    do_read(32'h0,  1'b0, 1'b1, 32'hB0000003);
    do_read(32'h0,  1'b0, 1'b1, 32'hB0000000);
    do_read(32'h0,  1'b0, 1'b1, 32'hB0000001);

    // Reset during WAIT aborts the read with no pulse
    select = 1'b1; read = 1'b1; start = 1'b1; address = 32'h10;
    @(negedge clk);
    check("abort_stall_accept", {31'd0, waitrequest}, 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    check("abort_stall_wait", {31'd0, waitrequest}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_readvalid",   {31'd0, readvalid}, 32'd0);
    check("abort_readdata",    readdata, 32'd0);
    check("abort_waitrequest", {31'd0, waitrequest}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    do_read(32'h10, 1'b1, 1'b0, 32'hDEADBEEF);

    // read & write together: write wins, no read response
    do_write(32'h30, 4'hF, 32'h55AA55AA, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    do_read(32'h30, 1'b1, 1'b0, 32'h55AA55AA);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
